simplerisc_prog_loader: RTL and testbench

- Streams assembler-level instruction fields in over a valid/ready handshake.
- Encodes each one into a 32-bit SimpleRISC instruction word and writes it sequentially into instruction memory through a single write port.
- It is the encoder counterpart of the instruction decoder: decoding any emitted word yields the requested opcode, I-bit and fields.
- Sits between the testbench/boot host and the instruction memory.

---
 rtl/simplerisc_pkg.sv | 55 +++++
 rtl/simplerisc_prog_loader_if.sv | 33 +++
 rtl/simplerisc_instr_pack.sv | 46 ++++
 rtl/simplerisc_prog_loader.sv | 127 ++++++++++++
 tb/tb_simplerisc_prog_loader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions for the program loader: opcode constants,
// instruction field bit positions, the loader state enum and opcode class helpers.
package simplerisc_pkg;

   // Opcodes (instruction bits [31:27])
   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_MUL  = 5'b00010;
   localparam logic [4:0] OP_DIV  = 5'b00011;
   localparam logic [4:0] OP_MOD  = 5'b00100;
   localparam logic [4:0] OP_CMP  = 5'b00101;
   localparam logic [4:0] OP_AND  = 5'b00110;
   localparam logic [4:0] OP_OR   = 5'b00111;
   localparam logic [4:0] OP_NOT  = 5'b01000;
   localparam logic [4:0] OP_MOV  = 5'b01001;
   localparam logic [4:0] OP_LSL  = 5'b01010;
   localparam logic [4:0] OP_LSR  = 5'b01011;
   localparam logic [4:0] OP_ASR  = 5'b01100;
   localparam logic [4:0] OP_NOP  = 5'b01101;
   localparam logic [4:0] OP_LD   = 5'b01110;
   localparam logic [4:0] OP_ST   = 5'b01111;
   localparam logic [4:0] OP_BEQ  = 5'b10000;
   localparam logic [4:0] OP_BGT  = 5'b10001;
   localparam logic [4:0] OP_B    = 5'b10010;
   localparam logic [4:0] OP_CALL = 5'b10011;
   localparam logic [4:0] OP_RET  = 5'b10100;

   // Field bit positions within the 32-bit instruction word
   localparam int OP_MSB     = 31;
   localparam int OP_LSB     = 27;
   localparam int I_BIT      = 26;
   localparam int RD_LSB     = 22;
   localparam int RS1_LSB    = 18;
   localparam int MOD_LSB    = 16;
   localparam int RS2_LSB    = 14;
   localparam int IMM_MSB    = 15;
   localparam int OFFSET_MSB = 26;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } load_state_t;

   // beq / bgt / b / call carry a 27-bit offset
   function automatic logic is_branch(input logic [4:0] op);
      return op inside {OP_BEQ, OP_BGT, OP_B, OP_CALL};
   endfunction

   // nop / ret carry no operands at all
   function automatic logic is_no_operand(input logic [4:0] op);
      return (op == OP_NOP) || (op == OP_RET);
   endfunction

endpackage

// File: rtl/simplerisc_prog_loader_if.sv
// Loader bus: the field-bundle stream (valid/ready) from the host and the
// single instruction-memory write port toward IMEM.
// master = host / memory side, slave = loader.
interface simplerisc_prog_loader_if #(
   parameter int IMEM_AW = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [4:0]         in_op;
   logic               in_imm;
   logic [1:0]         in_mod;
   logic [3:0]         in_rd;
   logic [3:0]         in_rs1;
   logic [3:0]         in_rs2;
   logic [15:0]        in_imm16;
   logic [26:0]        in_offset;

   logic               imem_we;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_wdata;

   modport master (
      output in_valid, in_op, in_imm, in_mod, in_rd, in_rs1, in_rs2, in_imm16, in_offset,
      input  in_ready,
      input  imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_op, in_imm, in_mod, in_rd, in_rs1, in_rs2, in_imm16, in_offset,
      output in_ready,
      output imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/simplerisc_instr_pack.sv
// Combinational encoder: assembler-level fields -> 32-bit SimpleRISC word.
// With ENC_LEGAL_CHECK_EN defined it also flags bundles that have no valid
// encoding; otherwise every bundle is legal and odd inputs are encoded leniently.
module simplerisc_instr_pack
   import simplerisc_pkg::*;
(
   input  logic [4:0]  op,
   input  logic        imm,
   input  logic [1:0]  mod,
   input  logic [3:0]  rd,
   input  logic [3:0]  rs1,
   input  logic [3:0]  rs2,
   input  logic [15:0] imm16,
   input  logic [26:0] offset,
   output logic [31:0] word,
   output logic        legal
);

   // Select the field layout by opcode class and pack the word
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      word  = '0;
      legal = 1'b1;
      word[OP_MSB:OP_LSB] = op;
      if (is_branch(op)) begin
         word[OFFSET_MSB:0] = offset;
      end else if (is_no_operand(op)) begin
         word[OFFSET_MSB:0] = '0;
      end else begin
         // ALU / ld / st format; opcodes above ret fall here too when unchecked
         word[I_BIT]          = imm;
         word[RD_LSB +: 4]    = (op == OP_CMP) ? 4'd0 : rd;
         word[RS1_LSB +: 4]   = (op == OP_NOT || op == OP_MOV) ? 4'd0 : rs1;
         if (imm) begin
            word[MOD_LSB +: 2]  = mod;
            word[IMM_MSB:0]     = imm16;
         end else begin
            word[RS2_LSB +: 4]  = rs2;
         end
      end
`ifdef ENC_LEGAL_CHECK_EN
      legal = (op <= OP_RET) && !(imm && (is_branch(op) || is_no_operand(op)));
`endif
   end

endmodule

// File: rtl/simplerisc_prog_loader.sv
// SimpleRISC program loader: accepts field bundles during a load session,
// encodes them and writes them to consecutive IMEM addresses from 0.
// Optional legality checking is enabled by defining ENC_LEGAL_CHECK_EN.
module simplerisc_prog_loader
   import simplerisc_pkg::*;
#(
   parameter int IMEM_AW = 8
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic                        finish,
   simplerisc_prog_loader_if.slave     bus,
   output logic [IMEM_AW:0]            count,
   output logic                        busy,
   output logic                        done,
   output logic                        overflow,
   output logic                        illegal
);

   // count value meaning "memory full" (== DEPTH)
   localparam logic [IMEM_AW:0] FULL = {1'b1, {IMEM_AW{1'b0}}};

   load_state_t        state_q, state_d;
   logic [IMEM_AW:0]   count_q;
   logic               overflow_q;
   logic               imem_we_q;
   logic [IMEM_AW-1:0] imem_addr_q;
   logic [31:0]        imem_wdata_q;
   logic [31:0]        word;
   logic               legal;
   logic               full;
   logic               accept;
   logic               overflow_hit;

   simplerisc_instr_pack u_pack (
      .op     (bus.in_op),
      .imm    (bus.in_imm),
      .mod    (bus.in_mod),
      .rd     (bus.in_rd),
      .rs1    (bus.in_rs1),
      .rs2    (bus.in_rs2),
      .imm16  (bus.in_imm16),
      .offset (bus.in_offset),
      .word   (word),
      .legal  (legal)
   );

   assign full         = (count_q == FULL);
   assign accept       = bus.in_valid && bus.in_ready;
   assign overflow_hit = (state_q == ST_LOAD) && bus.in_valid && full && !start;

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; start always (re)enters LOAD and beats finish
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_LOAD;
         ST_LOAD: begin
            if (start)                       state_d = ST_LOAD;
            else if (finish || overflow_hit) state_d = ST_DONE;
         end
         ST_DONE: if (start) state_d = ST_LOAD;
         default: state_d = ST_IDLE;
      endcase
   end

   // State decodes and the ready qualifier
   always_comb begin
      busy         = (state_q == ST_LOAD);
      done         = (state_q == ST_DONE);
      bus.in_ready = (state_q == ST_LOAD) && !full && !start && !finish;
   end

   // Write port, word counter and overflow flag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
      end else begin
         imem_we_q <= 1'b0;
         if (start) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
         end else begin
            if (accept && legal) begin
               imem_we_q    <= 1'b1;
               imem_addr_q  <= count_q[IMEM_AW-1:0];
               imem_wdata_q <= word;
               count_q      <= count_q + {{IMEM_AW{1'b0}}, 1'b1};
            end
            if (overflow_hit) overflow_q <= 1'b1;
         end
      end
   end

`ifdef ENC_LEGAL_CHECK_EN
   logic illegal_q;

   // Sticky flag for accepted-but-dropped bundles
   always_ff @(posedge clk) begin
      if (!reset_n)                   illegal_q <= 1'b0;
      else if (start)                 illegal_q <= 1'b0;
      else if (accept && !legal)      illegal_q <= 1'b1;
   end

   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = imem_wdata_q;
   assign count          = count_q;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_simplerisc_prog_loader.sv
// Scoreboard bench for simplerisc_prog_loader (IMEM_AW = 2, DEPTH = 4).
// Stimulus pushes each expected write; a monitor pops and compares on imem_we.
module tb_simplerisc_prog_loader;
   import simplerisc_pkg::*;

   localparam int AW = 2;
`ifdef ENC_LEGAL_CHECK_EN
   localparam bit LEGAL_CHK = 1'b1;
`else
   localparam bit LEGAL_CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        finish = 1'b0;
   logic [AW:0] count;
   logic        busy, done, overflow, illegal;

   simplerisc_prog_loader_if #(.IMEM_AW(AW)) bus ();

   simplerisc_prog_loader #(.IMEM_AW(AW)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .finish   (finish),
      .bus      (bus),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .illegal  (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic [AW:0]   cnt;
   } wr_t;

   wr_t sb[$];
   wr_t mon_e;
   int  wr_cyc[$];
   int  cyc = 0;
   int  n_pass = 0;
   int  n_total = 0;
   int  exp_count = 0;
   int  n0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
   endtask

   always @(posedge clk) cyc++;

   // Monitor: every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         wr_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got addr %0d data 0x%08h, wanted no write",
                     bus.imem_addr, bus.imem_wdata);
         end else begin
            mon_e = sb.pop_front();
            check("wr_addr",  32'(bus.imem_addr), 32'(mon_e.addr));
            check("wr_data",  bus.imem_wdata, mon_e.wdata);
            check("wr_count", 32'(count), 32'(mon_e.cnt));
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      exp_count = 0;
   endtask

   // Offer one bundle, wait (bounded) for the handshake, push the expected write
   task automatic send(input logic [4:0] op, input logic imm, input logic [1:0] mod,
                       input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [15:0] imm16, input logic [26:0] off,
                       input bit wr, input logic [31:0] exp_word);
      bit  got = 1'b0;
      wr_t e;
      bus.in_op = op;  bus.in_imm = imm;  bus.in_mod = mod;
      bus.in_rd = rd;  bus.in_rs1 = rs1;  bus.in_rs2 = rs2;
      bus.in_imm16 = imm16;  bus.in_offset = off;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (got) begin
         if (wr) begin
            e.addr  = AW'(exp_count);
            e.wdata = exp_word;
            exp_count++;
            e.cnt   = (AW+1)'(exp_count);
            sb.push_back(e);
         end
         @(posedge clk); #1;
      end else begin
         n_total++;
         $display("FAIL hs_timeout: got no in_ready for op %0d, wanted handshake", op);
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, wanted completion");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0;  bus.in_op = '0;  bus.in_imm = 1'b0;  bus.in_mod = '0;
      bus.in_rd = '0;  bus.in_rs1 = '0;  bus.in_rs2 = '0;
      bus.in_imm16 = '0;  bus.in_offset = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_we",       32'(bus.imem_we), 32'd0);
      check("rst_count",    32'(count),       32'd0);
      check("rst_busy",     32'(busy),        32'd0);
      check("rst_done",     32'(done),        32'd0);
      check("rst_overflow", 32'(overflow),    32'd0);
      check("rst_illegal",  32'(illegal),     32'd0);
      check("rst_ready",    32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Session 1: add r1,r2,r3
      pulse_start();
      @(negedge clk);
      check("start_busy",  32'(busy),         32'd1);
      check("start_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      send(OP_ADD, 1'b0, 2'd0, 4'd1, 4'd2, 4'd3, 16'h0, 27'h0, 1'b1, 32'h0048C000);
      @(negedge clk);
      check("add_latency_we", 32'(bus.imem_we), 32'd1);
      check("add_count",      32'(count),       32'd1);
      @(negedge clk);
      check("add_one_cycle",  32'(bus.imem_we), 32'd0);
      @(posedge clk); #1;

      // Session 2: restart, mov/b back-to-back, ret, finish
      pulse_start();
      @(negedge clk);
      check("restart_count", 32'(count), 32'd0);
      @(posedge clk); #1;
      n0 = wr_cyc.size();
      send(OP_MOV, 1'b1, 2'd0, 4'd5, 4'd7, 4'd3, 16'h1234, 27'h5, 1'b1, 32'h4D401234);
      send(OP_B, 1'b0, 2'd0, 4'hF, 4'hF, 4'hF, 16'hFFFF, 27'h10, 1'b1, 32'h90000010);
      @(negedge clk);
      @(posedge clk); #1;
      check("b2b_gap", (wr_cyc.size() >= n0 + 2) ? 32'(wr_cyc[n0+1] - wr_cyc[n0]) : 32'hFFFFFFFF, 32'd1);
      send(OP_RET, 1'b0, 2'd0, 4'd1, 4'd2, 4'd3, 16'h55, 27'h7, 1'b1, 32'hA0000000);
      bus.in_op = OP_ADD;
      bus.in_valid = 1'b1;
      finish = 1'b1;
      @(negedge clk);
      check("ready_with_finish", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      finish = 1'b0;
      @(negedge clk);
      check("finish_done",  32'(done),         32'd1);
      check("finish_busy",  32'(busy),         32'd0);
      check("done_ready",   32'(bus.in_ready), 32'd0);
      check("finish_count", 32'(count),        32'd3);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;

      // Session 3: fill the 4-word memory, then overflow
      pulse_start();
      send(OP_CMP, 1'b1, 2'd1, 4'd3, 4'd4, 4'd0, 16'hFFFF, 27'h0, 1'b1, 32'h2C11FFFF);
      send(OP_ST,  1'b0, 2'd0, 4'd2, 4'd3, 4'd4, 16'h0, 27'h0, 1'b1, 32'h788D0000);
      send(OP_NOT, 1'b0, 2'd0, 4'd6, 4'd9, 4'd9, 16'h0, 27'h0, 1'b1, 32'h41824000);
      send(OP_BEQ, 1'b0, 2'd0, 4'd1, 4'd1, 4'd1, 16'h0, 27'h7FFFFFF, 1'b1, 32'h87FFFFFF);
      @(negedge clk);
      check("full_count",    32'(count),         32'd4);
      check("full_ready",    32'(bus.in_ready),  32'd0);
      check("full_busy",     32'(busy),          32'd1);
      check("full_overflow", 32'(overflow),      32'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("ovf_flag",  32'(overflow),    32'd1);
      check("ovf_done",  32'(done),        32'd1);
      check("ovf_busy",  32'(busy),        32'd0);
      check("ovf_count", 32'(count),       32'd4);
      check("ovf_no_we", 32'(bus.imem_we), 32'd0);
      @(posedge clk); #1;

      // Session 4: illegal bundles (or lenient encoding without the check)
      pulse_start();
      @(negedge clk);
      check("start_clears_ovf", 32'(overflow), 32'd0);
      check("start_count",      32'(count),    32'd0);
      @(posedge clk); #1;
      send(5'h1F, 1'b0, 2'd0, 4'd1, 4'd1, 4'd1, 16'h0, 27'h0, !LEGAL_CHK, 32'hF8444000);
      @(negedge clk);
      check("op31_illegal", 32'(illegal), 32'(LEGAL_CHK));
      check("op31_count",   32'(count),   32'(exp_count));
      @(posedge clk); #1;
      send(OP_B, 1'b1, 2'd3, 4'd0, 4'd0, 4'd0, 16'hFFFF, 27'h3, !LEGAL_CHK, 32'h90000003);
      @(negedge clk);
      check("bimm_illegal", 32'(illegal), 32'(LEGAL_CHK));
      check("bimm_count",   32'(count),   32'(exp_count));
      @(posedge clk); #1;

      // Session 5: reset on the edge after a handshake
      pulse_start();
      send(OP_ADD, 1'b0, 2'd0, 4'd1, 4'd2, 4'd3, 16'h0, 27'h0, 1'b1, 32'h0048C000);
      reset_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("mrst_we",      32'(bus.imem_we),  32'd0);
      check("mrst_count",   32'(count),        32'd0);
      check("mrst_busy",    32'(busy),         32'd0);
      check("mrst_done",    32'(done),         32'd0);
      check("mrst_ready",   32'(bus.in_ready), 32'd0);
      check("mrst_illegal", 32'(illegal),      32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      exp_count = 0;

      repeat (2) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
